// File: rtl/input_router_pkg.sv
// Shared types and width helpers for the parametrised conv input router.
package input_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CAPTURE,
        ST_EMIT,
        ST_DONE
    } state_t;

    // Default geometry (64-bit SRAM word, 8-bit pixels).
    localparam int PIX_PER_WORD = 8;
    localparam int LANE_SEL_W   = $clog2(PIX_PER_WORD);
    // Input coordinates carry a sign bit plus one overflow bit above the map width.
    localparam int COORD_GUARD  = 2;

    function automatic int coord_w(input int addr_w);
        return addr_w + COORD_GUARD;
    endfunction

    function automatic int lane_sel_w(input int sram_w, input int data_w);
        return $clog2(sram_w / data_w);
    endfunction

endpackage

// File: rtl/tap_addr_calc.sv
// Combinational map from (output pixel, kernel tap, config) to input bounds check,
// SRAM word address and pixel slot within the word.
module tap_addr_calc
    import input_router_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int KW         = 3,
    parameter int SEL_W      = 3
) (
    input  logic [ADDR_WIDTH-1:0] i_ox,
    input  logic [ADDR_WIDTH-1:0] i_oy,
    input  logic [KW-1:0]         i_kx,
    input  logic [KW-1:0]         i_ky,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic [ADDR_WIDTH-1:0] i_pad,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    output logic                  o_in_bounds,
    output logic [ADDR_WIDTH-1:0] o_word_addr,
    output logic [SEL_W-1:0]      o_lane_sel
);
    localparam int AW = ADDR_WIDTH;
    localparam int CW = coord_w(ADDR_WIDTH);

    logic [2*AW-1:0]      w_oxs, w_oys, w_pix;
    logic signed [CW-1:0] w_ix, w_iy;
    logic                 w_x_ok, w_y_ok;

    assign w_oxs = {{AW{1'b0}}, i_ox} * {{AW{1'b0}}, i_stride};
    assign w_oys = {{AW{1'b0}}, i_oy} * {{AW{1'b0}}, i_stride};
    assign w_ix  = signed'(w_oxs[CW-1:0] + CW'(i_kx) - CW'(i_pad));
    assign w_iy  = signed'(w_oys[CW-1:0] + CW'(i_ky) - CW'(i_pad));

    assign w_x_ok      = !w_ix[CW-1] && (w_ix[CW-2:0] < {1'b0, i_i_size});
    assign w_y_ok      = !w_iy[CW-1] && (w_iy[CW-2:0] < {1'b0, i_i_size});
    assign o_in_bounds = w_x_ok && w_y_ok;

    assign w_pix = {{AW{1'b0}}, w_iy[AW-1:0]} * {{AW{1'b0}}, i_i_size}
                 + {{AW{1'b0}}, w_ix[AW-1:0]};

    // Word offset wraps modulo the address space by truncation.
    assign o_word_addr = i_start_addr + w_pix[SEL_W +: AW];
    assign o_lane_sel  = w_pix[SEL_W-1:0];

endmodule

// File: rtl/param_input_router.sv
// Walks a KxK window over a word-packed feature map and emits one ROW_COUNT-lane
// vector per kernel tap for each group of consecutive output pixels.
module param_input_router
    import input_router_pkg::*;
#(
    parameter int ROW_COUNT       = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int MAX_KERNEL      = 5
) (
    input  logic                                i_clk,
    input  logic                                i_nrst,
    input  logic                                i_reg_clear,
    input  logic                                i_start,
    input  logic [ADDR_WIDTH-1:0]               i_start_addr,
    input  logic [ADDR_WIDTH-1:0]               i_i_size,
    input  logic [ADDR_WIDTH-1:0]               i_o_size,
    input  logic [ADDR_WIDTH-1:0]               i_stride,
    input  logic [ADDR_WIDTH-1:0]               i_pad,
    input  logic [$clog2(MAX_KERNEL+1)-1:0]     i_kernel_size,
    output logic                                o_sram_rd_en,
    output logic [ADDR_WIDTH-1:0]               o_sram_rd_addr,
    input  logic [SRAM_DATA_WIDTH-1:0]          i_sram_rd_data,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic [ROW_COUNT*DATA_WIDTH-1:0]     o_data,
    output logic [ROW_COUNT-1:0]                o_lane_mask,
    output logic [$clog2(MAX_KERNEL**2)-1:0]    o_tap_idx,
    output logic                                o_last,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_err
);
    localparam int AW    = ADDR_WIDTH;
    localparam int KW    = $clog2(MAX_KERNEL+1);
    localparam int TW    = $clog2(MAX_KERNEL**2);
    localparam int LW    = (ROW_COUNT > 1) ? $clog2(ROW_COUNT) : 1;
    localparam int SEL_W = lane_sel_w(SRAM_DATA_WIDTH, DATA_WIDTH);

    state_t                      r_state;
    logic [AW-1:0]               r_start_addr, r_i_size, r_o_size, r_stride, r_pad;
    logic [KW-1:0]               r_k, r_kx, r_ky;
    logic [TW-1:0]               r_tap;
    logic [LW-1:0]               r_lane;
    logic [AW-1:0]               r_ox, r_gox;
    logic [AW:0]                 r_oy, r_goy;
    logic [SEL_W-1:0]            r_lane_sel;
    logic [ROW_COUNT*DATA_WIDTH-1:0] r_shadow_data, w_fill_data;
    logic [ROW_COUNT-1:0]        r_shadow_mask, w_fill_mask;

    logic                  w_in_bounds, w_lane_real, w_read, w_lane_done, w_lane_bit;
    logic                  w_ox_wrap, w_last_tap, w_cfg_ok;
    logic [AW-1:0]         w_word_addr, w_next_ox;
    logic [AW:0]           w_next_oy;
    logic [SEL_W-1:0]      w_lane_sel;
    logic [DATA_WIDTH-1:0] w_lane_val;

    tap_addr_calc #(.ADDR_WIDTH(AW), .KW(KW), .SEL_W(SEL_W)) u_calc (
        .i_ox        (r_ox),
        .i_oy        (r_oy[AW-1:0]),
        .i_kx        (r_kx),
        .i_ky        (r_ky),
        .i_stride    (r_stride),
        .i_pad       (r_pad),
        .i_i_size    (r_i_size),
        .i_start_addr(r_start_addr),
        .o_in_bounds (w_in_bounds),
        .o_word_addr (w_word_addr),
        .o_lane_sel  (w_lane_sel)
    );

    // oy >= o_size is equivalent to n >= o_size^2 since (ox,oy) track n incrementally.
    assign w_lane_real = r_oy < {1'b0, r_o_size};
    assign w_read      = (r_state == ST_FETCH) && w_lane_real && w_in_bounds;
    assign w_lane_done = ((r_state == ST_FETCH) && !w_read) || (r_state == ST_CAPTURE);
    assign w_ox_wrap   = (r_ox + AW'(1)) == r_o_size;
    assign w_next_ox   = w_ox_wrap ? '0 : r_ox + AW'(1);
    assign w_next_oy   = w_ox_wrap ? r_oy + (AW+1)'(1) : r_oy;
    assign w_last_tap  = (r_kx == r_k - KW'(1)) && (r_ky == r_k - KW'(1));
    assign w_cfg_ok    = (i_kernel_size != '0) && (i_kernel_size <= KW'(MAX_KERNEL))
                      && (i_stride != '0);

    // The read strobe is decoded from FETCH so data lands in CAPTURE one cycle later.
    assign o_sram_rd_en   = w_read && !i_reg_clear;
    assign o_sram_rd_addr = o_sram_rd_en ? w_word_addr : '0;

    always_comb begin
        w_lane_val  = (r_state == ST_CAPTURE)
                    ? i_sram_rd_data[r_lane_sel*DATA_WIDTH +: DATA_WIDTH] : '0;
        w_lane_bit  = (r_state == ST_CAPTURE) ? 1'b1 : w_lane_real;
        w_fill_data = r_shadow_data;
        w_fill_data[r_lane*DATA_WIDTH +: DATA_WIDTH] = w_lane_val;
        w_fill_mask = r_shadow_mask;
        w_fill_mask[r_lane] = w_lane_bit;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state <= ST_IDLE;
            r_start_addr <= '0; r_i_size <= '0; r_o_size <= '0; r_stride <= '0; r_pad <= '0;
            r_k <= '0; r_kx <= '0; r_ky <= '0; r_tap <= '0; r_lane <= '0;
            r_ox <= '0; r_oy <= '0; r_gox <= '0; r_goy <= '0; r_lane_sel <= '0;
            r_shadow_data <= '0; r_shadow_mask <= '0;
            o_valid <= 1'b0; o_data <= '0; o_lane_mask <= '0; o_tap_idx <= '0;
            o_last <= 1'b0; o_busy <= 1'b0; o_done <= 1'b0; o_err <= 1'b0;
        end else if (i_reg_clear) begin
            r_state <= ST_IDLE;
            r_start_addr <= '0; r_i_size <= '0; r_o_size <= '0; r_stride <= '0; r_pad <= '0;
            r_k <= '0; r_kx <= '0; r_ky <= '0; r_tap <= '0; r_lane <= '0;
            r_ox <= '0; r_oy <= '0; r_gox <= '0; r_goy <= '0; r_lane_sel <= '0;
            r_shadow_data <= '0; r_shadow_mask <= '0;
            o_valid <= 1'b0; o_data <= '0; o_lane_mask <= '0; o_tap_idx <= '0;
            o_last <= 1'b0; o_busy <= 1'b0; o_done <= 1'b0; o_err <= 1'b0;
        end else begin
            o_err  <= 1'b0;
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (i_start) begin
                    if (!w_cfg_ok) begin
                        o_err <= 1'b1;
                    end else begin
                        r_start_addr <= i_start_addr; r_i_size <= i_i_size;
                        r_o_size <= i_o_size; r_stride <= i_stride; r_pad <= i_pad;
                        r_k <= i_kernel_size;
                        r_kx <= '0; r_ky <= '0; r_tap <= '0; r_lane <= '0;
                        r_ox <= '0; r_oy <= '0; r_gox <= '0; r_goy <= '0;
                        if (i_o_size == '0) begin
                            r_state <= ST_DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state <= ST_FETCH;
                            o_busy  <= 1'b1;
                        end
                    end
                end
                ST_FETCH: if (w_read) begin
                    r_lane_sel <= w_lane_sel;
                    r_state    <= ST_CAPTURE;
                end
                ST_EMIT: if (i_ready) begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    if (o_last) begin
                        r_state <= ST_DONE;
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_FETCH;
                        if (w_last_tap) begin
                            r_kx <= '0; r_ky <= '0; r_tap <= '0;
                            r_gox <= r_ox; r_goy <= r_oy;
                        end else begin
                            r_ox <= r_gox; r_oy <= r_goy;
                            r_tap <= r_tap + TW'(1);
                            if (r_kx == r_k - KW'(1)) begin
                                r_kx <= '0;
                                r_ky <= r_ky + KW'(1);
                            end else begin
                                r_kx <= r_kx + KW'(1);
                            end
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            if (w_lane_done) begin
                r_shadow_data <= w_fill_data;
                r_shadow_mask <= w_fill_mask;
                r_ox <= w_next_ox;
                r_oy <= w_next_oy;
                if (r_lane == LW'(ROW_COUNT-1)) begin
                    r_lane      <= '0;
                    r_state     <= ST_EMIT;
                    o_valid     <= 1'b1;
                    o_data      <= w_fill_data;
                    o_lane_mask <= w_fill_mask;
                    o_tap_idx   <= r_tap;
                    o_last      <= w_last_tap && (w_next_oy >= {1'b0, r_o_size});
                end else begin
                    r_lane  <= r_lane + LW'(1);
                    r_state <= ST_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_input_router.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// randomized jobs compared against a coordinate-level reference model.
module tb_param_input_router;
    localparam int R = 4, DW = 8, SW = 64, AW = 8, MK = 5, KW = 3, TW = 5;

    typedef struct { int i_sz, o_sz, k, s, pad, sa; } cfg_t;
    typedef struct { logic [R*DW-1:0] data; logic [R-1:0] mask; int tap; bit last; } vec_t;
    typedef struct {
        int i_sz, o_sz, k, s, pad, exp_vecs, exp_reads;
        int p0_idx; logic [R*DW-1:0] p0_data; logic [R-1:0] p0_mask;
        int p1_idx; logic [R*DW-1:0] p1_data; logic [R-1:0] p1_mask;
    } tv_t;

    logic clk = 1'b0, nrst = 1'b0, clr = 1'b0, start = 1'b0, ready = 1'b0;
    logic [AW-1:0] sa = '0, isz = '0, osz = '0, str = '0, pad = '0;
    logic [KW-1:0] ks = '0;
    logic rd_en, valid, last, busy, done, err;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_data;
    logic [R*DW-1:0] data;
    logic [R-1:0] mask;
    logic [TW-1:0] tap;
    logic [54:0] all_outs;

    logic [SW-1:0] mem [256];
    int n_vec = 0, n_bad = 0, exp_reads = 0;
    vec_t exp_q[$], got_q[$];
    tv_t tbl[5];

    always #5 clk = ~clk;
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
    assign all_outs = {rd_en, rd_addr, valid, data, mask, tap, last, busy, done, err};

    param_input_router #(.ROW_COUNT(R), .DATA_WIDTH(DW), .SRAM_DATA_WIDTH(SW),
                         .ADDR_WIDTH(AW), .MAX_KERNEL(MK)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_reg_clear(clr), .i_start(start),
        .i_start_addr(sa), .i_i_size(isz), .i_o_size(osz), .i_stride(str), .i_pad(pad),
        .i_kernel_size(ks), .o_sram_rd_en(rd_en), .o_sram_rd_addr(rd_addr),
        .i_sram_rd_data(rd_data), .o_valid(valid), .i_ready(ready), .o_data(data),
        .o_lane_mask(mask), .o_tap_idx(tap), .o_last(last), .o_busy(busy),
        .o_done(done), .o_err(err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: every output pixel/tap resolved with plain division and modulo.
    task automatic model(input cfg_t c);
        int groups, n, ox, oy, ix, iy, p, w, b;
        vec_t v;
        exp_q.delete();
        exp_reads = 0;
        groups = (c.o_sz * c.o_sz + R - 1) / R;
        for (int g = 0; g < groups; g++) begin
            for (int t = 0; t < c.k * c.k; t++) begin
                v.data = '0; v.mask = '0; v.tap = t;
                v.last = (g == groups - 1) && (t == c.k * c.k - 1);
                for (int r = 0; r < R; r++) begin
                    n = g * R + r;
                    if (n < c.o_sz * c.o_sz) begin
                        ox = n % c.o_sz; oy = n / c.o_sz;
                        ix = ox * c.s + t % c.k - c.pad;
                        iy = oy * c.s + t / c.k - c.pad;
                        v.mask[r] = 1'b1;
                        if (ix >= 0 && ix < c.i_sz && iy >= 0 && iy < c.i_sz) begin
                            p = iy * c.i_sz + ix;
                            w = (c.sa + p / 8) % 256;
                            b = p % 8;
                            v.data[r*DW +: DW] = mem[w][b*8 +: 8];
                            exp_reads++;
                        end
                    end
                end
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic drive_cfg(input cfg_t c);
        sa = AW'(c.sa); isz = AW'(c.i_sz); osz = AW'(c.o_sz);
        str = AW'(c.s); pad = AW'(c.pad); ks = KW'(c.k);
    endtask

    task automatic run_job(input cfg_t c, input int rdy_pct, input int hold_at,
                           input bit inject, output int nreads);
        vec_t e, g;
        int hold, last_hs, done_cyc, exp_n;
        bit prev_hold, rdy;
        logic [R*DW-1:0] snap_d;
        logic [R-1:0] snap_m;
        logic [TW-1:0] snap_t;
        hold = 0; last_hs = -10; done_cyc = -1; prev_hold = 1'b0; nreads = 0;
        snap_d = '0; snap_m = '0; snap_t = '0;
        model(c);
        exp_n = exp_q.size();
        got_q.delete();
        @(negedge clk); drive_cfg(c); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy, c.o_sz != 0);
        for (int cyc = 0; cyc < 20000 && done_cyc < 0; cyc++) begin
            if (rd_en) nreads++;
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (inject && cyc == 3) begin start = 1'b1; ks = 1; osz = 1; end
                if (inject && cyc == 4) start = 1'b0;
                if (valid && prev_hold)
                    check("hold_stable", {data, mask, tap}, {snap_d, snap_m, snap_t});
                rdy = ($urandom_range(99) < rdy_pct);
                if (hold_at == got_q.size() && valid && hold < 5) begin
                    rdy = 1'b0; hold++;
                    check("no_read_in_hold", rd_en, 0);
                end
                ready = rdy;
                if (valid && rdy) begin
                    g.data = data; g.mask = mask; g.tap = int'(tap); g.last = last;
                    got_q.push_back(g);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check($sformatf("vec%0d", got_q.size() - 1), {data, mask, tap, last},
                              {e.data, e.mask, TW'(e.tap), e.last});
                    end
                    last_hs = cyc;
                end
                prev_hold = valid && !rdy;
                snap_d = data; snap_m = mask; snap_t = tap;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        check("done_seen", done_cyc >= 0, 1);
        check("done_pulse_cleared", done, 0);
        if (exp_n > 0) check("done_latency", done_cyc, last_hs + 1);
        check("vec_count", got_q.size(), exp_n);
        check("rd_count", nreads, exp_reads);
        check("busy_cleared", busy, 0);
    endtask

    task automatic err_case(input int k, input int s);
        @(negedge clk); ks = KW'(k); str = AW'(s); isz = 4; osz = 2; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check($sformatf("err_pulse_k%0d_s%0d", k, s), {err, busy, rd_en}, 3'b100);
        @(negedge clk);
        check("err_cleared", {err, busy, rd_en}, 0);
    endtask

    initial begin
        cfg_t c;
        int nr;
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 8; b++) mem[w][b*8 +: 8] = 8'(w * 8 + b);

        tbl[0] = '{4, 2, 3, 1, 0, 9, 36, 0, 32'h05040100, 4'hF, 8, 32'h0F0E0B0A, 4'hF};
        tbl[1] = '{4, 4, 3, 1, 1, 36, 100, 0, 32'h00000000, 4'hF, 4, 32'h03020100, 4'hF};
        tbl[2] = '{4, 3, 1, 1, 0, 3, 9, 0, 32'h04020100, 4'hF, 2, 32'h0000000A, 4'h1};
        tbl[3] = '{5, 2, 3, 2, 0, 9, 36, 0, 32'h0C0A0200, 4'hF, 8, 32'h18160E0C, 4'hF};
        tbl[4] = '{4, 0, 3, 1, 0, 0, 0, -1, 32'h0, 4'h0, -1, 32'h0, 4'h0};

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs, 0);
        nrst = 1'b1;

        foreach (tbl[t]) begin
            c = '{tbl[t].i_sz, tbl[t].o_sz, tbl[t].k, tbl[t].s, tbl[t].pad, 0};
            run_job(c, 75, -1, 1'b0, nr);
            check($sformatf("tbl%0d_vecs", t), got_q.size(), tbl[t].exp_vecs);
            check($sformatf("tbl%0d_reads", t), nr, tbl[t].exp_reads);
            if (tbl[t].p0_idx >= 0 && got_q.size() > tbl[t].p0_idx)
                check($sformatf("tbl%0d_probe0", t),
                      {got_q[tbl[t].p0_idx].data, got_q[tbl[t].p0_idx].mask},
                      {tbl[t].p0_data, tbl[t].p0_mask});
            if (tbl[t].p1_idx >= 0 && got_q.size() > tbl[t].p1_idx)
                check($sformatf("tbl%0d_probe1", t),
                      {got_q[tbl[t].p1_idx].data, got_q[tbl[t].p1_idx].mask},
                      {tbl[t].p1_data, tbl[t].p1_mask});
        end

        // Backpressure hold on the third vector, then i_start while busy.
        c = '{4, 2, 3, 1, 0, 0};
        run_job(c, 100, 2, 1'b0, nr);
        c = '{4, 4, 3, 1, 1, 0};
        run_job(c, 80, -1, 1'b1, nr);

        // Async reset in the middle of a capture, then a clean rerun.
        c = '{4, 2, 3, 1, 0, 0};
        @(negedge clk); drive_cfg(c); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && !rd_en; i++) @(negedge clk);
        check("saw_read_before_reset", rd_en, 1);
        @(negedge clk);
        nrst = 1'b0;
        #1 check("async_reset_outputs", all_outs, 0);
        @(negedge clk); @(negedge clk); nrst = 1'b1;
        run_job(c, 70, -1, 1'b0, nr);

        // Synchronous clear beats a simultaneous start.
        c = '{4, 3, 1, 1, 0, 0};
        @(negedge clk); drive_cfg(c); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        check("clear_outputs", all_outs, 0);
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        check("clear_idle", {busy, rd_en, valid}, 0);

        err_case(0, 1);
        err_case(6, 1);
        err_case(3, 0);

        for (int j = 0; j < 10; j++) begin
            for (int w = 0; w < 256; w++) mem[w] = {$urandom, $urandom};
            c.i_sz = $urandom_range(10, 1); c.o_sz = $urandom_range(5, 0);
            c.k = $urandom_range(5, 1); c.s = $urandom_range(3, 1);
            c.pad = $urandom_range(2, 0); c.sa = $urandom_range(255, 0);
            run_job(c, 65, (j == 0) ? 1 : -1, 1'b0, nr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
